// File: rtl/shift_seq_gen.sv
// -----------------------------------------------------------------------------
// shift_seq_gen
//
// WIDTH-bit shift-register sequence generator with selectable feedback. It can
// run as a rotating ring (one-hot sequencer), a Johnson counter, or a Fibonacci
// LFSR (pattern source or scrambler). Mode 11 holds the current state.
//
// Beyond the raw state it keeps a "start reference": the value last loaded by
// reset, load, or lock-up recovery. Each time a step lands back on that value,
// it pulses wrap. It also reports, in period, how many steps the lap took.
//
// Ports
//   clk       in   1      clock, all state updates on the rising edge
//   rst       in   1      synchronous active-high reset
//   en        in   1      take one step this cycle (ignored in hold mode)
//   mode      in   2      00 ring, 01 Johnson, 10 LFSR, 11 hold
//   load      in   1      load load_val as new state and start reference
//   load_val  in   WIDTH  value used by load
//   out       out  WIDTH  current state (registered)
//   wrap      out  1      one-cycle pulse; out now shows the start reference
//                         again after a step
//   lockup    out  1      one-cycle pulse; an all-zero LFSR state was
//                         replaced by SEED
//   period    out  CW     steps taken between the last two start-reference
//                         hits; saturates at all-ones
//
// Control handshake: load and en are plain per-cycle strobes with no ready
// back-pressure. The generator accepts them in every cycle, with priority
// rst > load > en. Their effect is visible on out one clock later.
// -----------------------------------------------------------------------------
module shift_seq_gen #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b0011,
  parameter logic [WIDTH-1:0] SEED  = 4'b0001,
  parameter int               CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             lockup,
  output logic [CW-1:0]    period
);

  typedef enum logic [1:0] {
    MODE_RING    = 2'b00,
    MODE_JOHNSON = 2'b01,
    MODE_LFSR    = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  // Registered state
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] ref_q;      // start reference for wrap detection
  logic [CW-1:0]    cnt_q;      // steps since the last start-reference hit
  logic [CW-1:0]    period_q;
  logic             wrap_q;
  logic             lockup_q;

  // Next-state values
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] ref_d;
  logic [CW-1:0]    cnt_d;
  logic [CW-1:0]    period_d;
  logic             wrap_d;
  logic             lockup_d;

  // Step datapath
  mode_t            mode_e;
  logic             fb;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt_inc;
  logic             do_step;
  logic             do_lock;
  logic             ref_hit;

  assign mode_e = mode_t'(mode);

  // Feedback bit and the shifted candidate state. Every active mode
  // shifts right. Only the bit entering at the MSB differs.
  always_comb begin
    fb = state_q[0];
    unique case (mode_e)
      MODE_RING:    fb = state_q[0];
      MODE_JOHNSON: fb = ~state_q[0];
      MODE_LFSR:    fb = ^(state_q & TAPS);
      MODE_HOLD:    fb = state_q[0];
      default:      fb = state_q[0];
    endcase
    shifted = {fb, state_q[WIDTH-1:1]};
  end

  // The counter saturates at CNT_MAX. If this lap's count is already
  // saturated, the reported period saturates as well.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  assign do_step = en && (mode_e != MODE_HOLD);
  // An all-zero LFSR state can never leave zero, so the next step
  // reseeds instead. All-zero is legitimate in ring/Johnson mode and is
  // left alone there.
  assign do_lock = en && (mode_e == MODE_LFSR) && (state_q == '0);
  assign ref_hit = (shifted == ref_q);

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;

    if (load) begin
      state_d = load_val;
      ref_d   = load_val;
      cnt_d   = '0;
    end else if (do_lock) begin
      state_d  = SEED;
      ref_d    = SEED;
      cnt_d    = '0;
      lockup_d = 1'b1;
    end else if (do_step) begin
      state_d = shifted;
      if (ref_hit) begin
        wrap_d   = 1'b1;
        period_d = cnt_inc;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEED;
      ref_q    <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign out    = state_q;
  assign wrap   = wrap_q;
  assign lockup = lockup_q;
  assign period = period_q;

endmodule

// File: tb/tb_shift_seq_gen.sv
module tb_shift_seq_gen;

  localparam int         W    = 4;
  localparam logic [3:0] TAPS = 4'b0011;
  localparam logic [3:0] SEED = 4'b0001;
  localparam int         EW   = 4 + 1 + 1 + 8 + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] load_val = 4'h0;

  // Two instances share stimulus: CW=8 (normal) and CW=3 (saturation).
  logic [3:0] out_a, out_b;
  logic       wrap_a, wrap_b, lock_a, lock_b;
  logic [7:0] per_a;
  logic [2:0] per_b;

  shift_seq_gen #(.WIDTH(4), .TAPS(TAPS), .SEED(SEED), .CW(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .out(out_a), .wrap(wrap_a), .lockup(lock_a), .period(per_a)
  );

  shift_seq_gen #(.WIDTH(4), .TAPS(TAPS), .SEED(SEED), .CW(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .out(out_b), .wrap(wrap_b), .lockup(lock_b), .period(per_b)
  );

  // ---------------- reference model ----------------
  // Abstract view: the state is a number. Steps are computed arithmetically.
  // Steps since the last reference hit are counted without limit, and
  // saturation is applied only when a period is reported.
  int         m_out = 1;
  int         m_ref = 1;
  int         m_steps = 0;
  int         m_per8 = 0;
  int         m_per3 = 0;
  bit         m_wrap = 0;
  bit         m_lock = 0;

  function automatic int next_val(input int m, input int s);
    int msb;
    case (m)
      0:       msb = s % 2;
      1:       msb = 1 - (s % 2);
      default: msb = $countones(4'(s) & TAPS) % 2;
    endcase
    return (s / 2) + msb * (1 << (W - 1));
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_step(input bit r, input bit l, input bit e, input int m, input int v);
    int n;
    m_wrap = 0;
    m_lock = 0;
    if (r) begin
      m_out = SEED; m_ref = SEED; m_steps = 0; m_per8 = 0; m_per3 = 0;
    end else if (l) begin
      m_out = v; m_ref = v; m_steps = 0;
    end else if (e && m != 3) begin
      if (m == 2 && m_out == 0) begin
        m_out = SEED; m_ref = SEED; m_steps = 0; m_lock = 1;
      end else begin
        n = next_val(m, m_out);
        m_steps++;
        if (n == m_ref) begin
          m_wrap  = 1;
          m_per8  = sat(m_steps, 255);
          m_per3  = sat(m_steps, 7);
          m_steps = 0;
        end
        m_out = n;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit r, input bit l, input bit e, input logic [1:0] m, input logic [3:0] v);
    logic [EW-1:0] ex;
    rst = r; load = l; en = e; mode = m; load_val = v;
    model_step(r, l, e, int'(m), int'(v));
    exp_q.push_back({4'(m_out), m_wrap, m_lock, 8'(m_per8), 3'(m_per3)});
    @(posedge clk);
    #1;
    ex = exp_q.pop_front();
    check("out_a",  32'(out_a),  32'(ex[16:13]));
    check("out_b",  32'(out_b),  32'(ex[16:13]));
    check("wrap_a", 32'(wrap_a), 32'(ex[12]));
    check("wrap_b", 32'(wrap_b), 32'(ex[12]));
    check("lock_a", 32'(lock_a), 32'(ex[11]));
    check("lock_b", 32'(lock_b), 32'(ex[11]));
    check("per_a",  32'(per_a),  32'(ex[10:3]));
    check("per_b",  32'(per_b),  32'(ex[2:0]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    cyc(1, 0, 0, 2'b00, 4'h0);
    check("rst_out", 32'(out_a), 32'h1);
    check("rst_per", 32'(per_a), 32'h0);

    // 1: LFSR from reset, 15 steps back to seed
    cyc(0, 0, 1, 2'b10, 4'h0);
    check("lfsr_first", 32'(out_a), 32'h8);
    for (int i = 1; i < 15; i++) cyc(0, 0, 1, 2'b10, 4'h0);
    check("lfsr_wrap", 32'(wrap_a), 32'h1);
    check("lfsr_period", 32'(per_a), 32'd15);
    check("lfsr_period_sat", 32'(per_b), 32'd7);

    // 2: ring from 0001
    cyc(0, 1, 1, 2'b00, 4'h1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 2'b00, 4'h0);
    check("ring_period", 32'(per_a), 32'd4);

    // 3: Johnson from 0000
    cyc(0, 1, 0, 2'b01, 4'h0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 2'b01, 4'h0);
    check("john_wrap", 32'(wrap_a), 32'h1);
    check("john_period", 32'(per_a), 32'd8);

    // 4: LFSR lock-up recovery, then a full lap
    cyc(0, 1, 0, 2'b10, 4'h0);
    cyc(0, 0, 1, 2'b10, 4'h0);
    check("lock_pulse", 32'(lock_a), 32'h1);
    check("lock_out", 32'(out_a), 32'h1);
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 2'b10, 4'h0);
    check("lock_lap_period", 32'(per_a), 32'd15);

    // 5: priority and hold
    cyc(0, 1, 1, 2'b10, 4'h6);
    check("load_over_en", 32'(out_a), 32'h6);
    cyc(0, 0, 1, 2'b00, 4'h0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 2'b11, 4'h0);
    check("hold_out", 32'(out_a), 32'h3);
    cyc(1, 1, 1, 2'b00, 4'h9);
    check("rst_over_load", 32'(out_a), 32'h1);
    check("rst_period", 32'(per_a), 32'h0);

    // 6: saturation instance, explicit lap from load
    cyc(0, 1, 0, 2'b10, 4'h1);
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 2'b10, 4'h0);
    check("sat_wrap", 32'(wrap_b), 32'h1);
    check("sat_period", 32'(per_b), 32'd7);

    // Mixed mode change keeps reference and count
    cyc(0, 1, 0, 2'b00, 4'h1);
    cyc(0, 0, 1, 2'b00, 4'h0);
    cyc(0, 0, 1, 2'b01, 4'h0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 2'b10, 4'h0);

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0),
          ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 3) != 0),
          2'($urandom_range(0, 3)),
          4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
